// File: rtl/flash_arbiter.sv
// Two-requester arbiter in front of a read-only flash controller.
// One transaction at a time: grant in IDLE, read in BUSY, one-cycle ready pulse in RESP.
module flash_arbiter #(
  parameter int FIXED_PRIORITY = 0
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [31:0] m0_address_in,
  input  logic        m0_sel_in,
  input  logic        m0_read_in,
  input  logic [3:0]  m0_write_mask_in,
  output logic [31:0] m0_read_value_out,
  output logic        m0_ready_out,
  input  logic [31:0] m1_address_in,
  input  logic        m1_sel_in,
  input  logic        m1_read_in,
  input  logic [3:0]  m1_write_mask_in,
  output logic [31:0] m1_read_value_out,
  output logic        m1_ready_out,
  output logic [31:0] flash_address_out,
  output logic        flash_sel_out,
  output logic        flash_read_out,
  input  logic [31:0] flash_read_value_in,
  input  logic        flash_ready_in
);

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    BUSY = 2'b01,
    RESP = 2'b10
  } state_t;

  state_t      state_reg;
  state_t      state_next;
  logic        grant_reg;
  logic [23:0] addr_reg;
  logic [31:0] data_reg;

  logic [23:0] addr_in  [2];
  logic [3:0]  mask_in  [2];
  logic [1:0]  sel_in;
  logic [1:0]  read_in;
  logic [1:0]  req;
  logic [1:0]  is_read;
  logic [1:0]  ready;
  logic [31:0] value    [2];

  logic        grant_sel;
  logic        granted_is_read;
  logic [23:0] granted_addr;
  logic        busy;

  // Only the low 24 address bits reach the flash; the top byte is discarded.
  logic unused_addr_hi;
  assign unused_addr_hi = ^{m0_address_in[31:24], m1_address_in[31:24]};

  assign addr_in[0] = m0_address_in[23:0];
  assign addr_in[1] = m1_address_in[23:0];
  assign mask_in[0] = m0_write_mask_in;
  assign mask_in[1] = m1_write_mask_in;
  assign sel_in     = {m1_sel_in, m0_sel_in};
  assign read_in    = {m1_read_in, m0_read_in};

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_port
      assign req[gi]     = sel_in[gi] & (read_in[gi] | (|mask_in[gi]));
      assign is_read[gi] = sel_in[gi] & read_in[gi];
      assign ready[gi]   = (state_reg == RESP) && (grant_reg == 1'(gi));
      assign value[gi]   = (ready[gi] && sel_in[gi]) ? data_reg : 32'h0;
    end
  endgenerate

  assign m0_ready_out      = ready[0];
  assign m1_ready_out      = ready[1];
  assign m0_read_value_out = value[0];
  assign m1_read_value_out = value[1];

  // grant_reg doubles as last_grant: on contention round-robin picks the other port.
  always_comb begin
    grant_sel = grant_reg;
    if (req[0] && req[1]) begin
      grant_sel = (FIXED_PRIORITY != 0) ? 1'b0 : ~grant_reg;
    end else if (req[0]) begin
      grant_sel = 1'b0;
    end else if (req[1]) begin
      grant_sel = 1'b1;
    end
  end

  assign granted_is_read = is_read[grant_sel];
  assign granted_addr    = addr_in[grant_sel];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE: begin
        if (|req) begin
          state_next = granted_is_read ? BUSY : RESP;
        end
      end
      BUSY: begin
        if (flash_ready_in) begin
          state_next = RESP;
        end
      end
      RESP:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Data is cleared on every grant so write-only transactions answer with zero.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      grant_reg <= 1'b1;
      addr_reg  <= 24'h0;
      data_reg  <= 32'h0;
    end else if (state_reg == IDLE && (|req)) begin
      grant_reg <= grant_sel;
      addr_reg  <= granted_addr;
      data_reg  <= 32'h0;
    end else if (state_reg == BUSY && flash_ready_in) begin
      data_reg  <= flash_read_value_in;
    end
  end

  assign busy              = (state_reg == BUSY);
  assign flash_sel_out     = busy;
  assign flash_read_out    = busy;
  assign flash_address_out = busy ? {8'h00, addr_reg} : 32'h0;

endmodule

// File: tb/tb_flash_arbiter.sv
// Randomized and directed bench for flash_arbiter against a transaction-level model.
// Two instances (round-robin and fixed priority) share every input.
module tb_flash_arbiter;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [31:0] m0_address, m1_address;
  logic        m0_sel, m0_read, m1_sel, m1_read;
  logic [3:0]  m0_mask, m1_mask;
  logic [31:0] flash_value;
  logic        flash_ready;

  logic [31:0] m0_value, m1_value, flash_address;
  logic        m0_ready, m1_ready, flash_sel, flash_read;
  logic [31:0] fp_m0_value, fp_m1_value, fp_flash_address;
  logic        fp_m0_ready, fp_m1_ready, fp_flash_sel, fp_flash_read;

  int checks   = 0;
  int failures = 0;
  int model_last = 1;
  int txn_id = 0;

  always #5 clk = ~clk;

  flash_arbiter #(.FIXED_PRIORITY(0)) dut (
    .clk(clk), .reset_n(reset_n),
    .m0_address_in(m0_address), .m0_sel_in(m0_sel), .m0_read_in(m0_read),
    .m0_write_mask_in(m0_mask), .m0_read_value_out(m0_value), .m0_ready_out(m0_ready),
    .m1_address_in(m1_address), .m1_sel_in(m1_sel), .m1_read_in(m1_read),
    .m1_write_mask_in(m1_mask), .m1_read_value_out(m1_value), .m1_ready_out(m1_ready),
    .flash_address_out(flash_address), .flash_sel_out(flash_sel), .flash_read_out(flash_read),
    .flash_read_value_in(flash_value), .flash_ready_in(flash_ready)
  );

  flash_arbiter #(.FIXED_PRIORITY(1)) dut_fp (
    .clk(clk), .reset_n(reset_n),
    .m0_address_in(m0_address), .m0_sel_in(m0_sel), .m0_read_in(m0_read),
    .m0_write_mask_in(m0_mask), .m0_read_value_out(fp_m0_value), .m0_ready_out(fp_m0_ready),
    .m1_address_in(m1_address), .m1_sel_in(m1_sel), .m1_read_in(m1_read),
    .m1_write_mask_in(m1_mask), .m1_read_value_out(fp_m1_value), .m1_ready_out(fp_m1_ready),
    .flash_address_out(fp_flash_address), .flash_sel_out(fp_flash_sel), .flash_read_out(fp_flash_read),
    .flash_read_value_in(flash_value), .flash_ready_in(flash_ready)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    m0_address = 32'h0; m0_sel = 1'b0; m0_read = 1'b0; m0_mask = 4'h0;
    m1_address = 32'h0; m1_sel = 1'b0; m1_read = 1'b0; m1_mask = 4'h0;
    flash_ready = 1'b0; flash_value = 32'h0;
  endtask

  // Called with the DUT idle and the request inputs already driven for this cycle.
  task automatic run_txn(input int lat, input logic [31:0] data, input bit drop,
                         input bit scramble, input bit check_fp, output int got_grant);
    bit          r0, r1, rd, g_sel;
    int          g, fp_g;
    logic [31:0] a_full;
    logic [31:0] exp_addr;
    logic [31:0] exp_val;
    #1;
    r0 = m0_sel && (m0_read || (m0_mask != 4'h0));
    r1 = m1_sel && (m1_read || (m1_mask != 4'h0));
    got_grant = -1;
    check_eq("req_cycle_ready0", {31'h0, m0_ready}, 32'h0);
    check_eq("req_cycle_ready1", {31'h0, m1_ready}, 32'h0);
    check_eq("req_cycle_flash_sel", {31'h0, flash_sel}, 32'h0);
    // Flash ready outside BUSY must be ignored.
    flash_ready = 1'($urandom_range(0, 1));
    flash_value = $urandom;
    if (!r0 && !r1) begin
      step();
      check_eq("idle_stays_idle", {31'h0, flash_sel}, 32'h0);
      $display("txn %0d: no request", txn_id);
      txn_id++;
      return;
    end
    if (r0 && r1) g = 1 - model_last;
    else g = r0 ? 0 : 1;
    fp_g = (r0 && r1) ? 0 : g;
    model_last = g;
    rd     = (g == 0) ? (m0_sel && m0_read) : (m1_sel && m1_read);
    a_full = (g == 0) ? m0_address : m1_address;
    exp_addr = {8'h00, a_full[23:0]};
    step();
    if (rd) begin
      for (int i = 1; i <= lat; i++) begin
        check_eq("busy_flash_sel", {31'h0, flash_sel}, 32'h1);
        check_eq("busy_flash_read", {31'h0, flash_read}, 32'h1);
        check_eq("busy_flash_addr", flash_address, exp_addr);
        check_eq("busy_ready", {30'h0, m1_ready, m0_ready}, 32'h0);
        if (scramble) begin
          m0_address = $urandom;
          m1_address = $urandom;
        end
        if (drop && i == 1) begin
          if (g == 0) m0_sel = 1'b0;
          else m1_sel = 1'b0;
        end
        flash_ready = (i == lat);
        flash_value = (i == lat) ? data : $urandom;
        step();
      end
    end
    flash_ready = 1'($urandom_range(0, 1));
    flash_value = $urandom;
    #1;
    g_sel = (g == 0) ? m0_sel : m1_sel;
    exp_val = (g_sel && rd) ? data : 32'h0;
    check_eq("resp_flash_sel", {31'h0, flash_sel}, 32'h0);
    check_eq("resp_ready0", {31'h0, m0_ready}, (g == 0) ? 32'h1 : 32'h0);
    check_eq("resp_ready1", {31'h0, m1_ready}, (g == 1) ? 32'h1 : 32'h0);
    check_eq("resp_value0", m0_value, (g == 0) ? exp_val : 32'h0);
    check_eq("resp_value1", m1_value, (g == 1) ? exp_val : 32'h0);
    if (check_fp) begin
      check_eq("fp_ready0", {31'h0, fp_m0_ready}, (fp_g == 0) ? 32'h1 : 32'h0);
      check_eq("fp_ready1", {31'h0, fp_m1_ready}, (fp_g == 1) ? 32'h1 : 32'h0);
    end
    if (m0_ready && !m1_ready) got_grant = 0;
    else if (m1_ready && !m0_ready) got_grant = 1;
    $display("txn %0d: grant=%0d %s lat=%0d value=%h", txn_id, g, rd ? "read" : "write",
             rd ? lat : 0, exp_val);
    txn_id++;
    step();
    flash_ready = 1'b0;
    check_eq("pulse_one_cycle", {30'h0, m1_ready, m0_ready}, 32'h0);
  endtask

  int gg;
  int exp_order[4] = '{0, 1, 0, 1};

  initial begin
    reset_n = 1'b0;
    clear_inputs();
    step();
    step();
    check_eq("rst_flash_sel", {31'h0, flash_sel}, 32'h0);
    check_eq("rst_flash_addr", flash_address, 32'h0);
    check_eq("rst_ready", {28'h0, fp_m1_ready, fp_m0_ready, m1_ready, m0_ready}, 32'h0);
    check_eq("rst_values", m0_value | m1_value, 32'h0);
    reset_n = 1'b1;
    model_last = 1;
    step();

    // Long-latency single read on port 0.
    m0_sel = 1'b1; m0_read = 1'b1; m0_address = 32'h0000_0100;
    run_txn(66, 32'hDEAD_BEEF, 1'b0, 1'b0, 1'b0, gg);
    check_eq("long_read_grant", gg, 0);
    clear_inputs();

    // Write-only on port 1: no flash access, zero data.
    m1_sel = 1'b1; m1_mask = 4'hF; m1_address = 32'h0000_0040;
    run_txn(1, 32'h0, 1'b0, 1'b0, 1'b0, gg);
    check_eq("write_grant", gg, 1);
    clear_inputs();

    // Address truncation and stability while the requester changes its address.
    m0_sel = 1'b1; m0_read = 1'b1; m0_address = 32'hAB12_3456;
    run_txn(5, 32'hCAFE_F00D, 1'b0, 1'b1, 1'b0, gg);
    clear_inputs();

    // Requester drops select mid-transaction: pulse still comes, data gated.
    m0_sel = 1'b1; m0_read = 1'b1; m0_address = 32'h0000_2000;
    run_txn(4, 32'h1234_5678, 1'b1, 1'b0, 1'b0, gg);
    clear_inputs();

    // Reset in the middle of a read.
    m0_sel = 1'b1; m0_read = 1'b1; m0_address = 32'h0000_0300;
    step();
    check_eq("pre_reset_busy", {31'h0, flash_sel}, 32'h1);
    reset_n = 1'b0;
    #1;
    check_eq("reset_kills_sel", {31'h0, flash_sel}, 32'h0);
    check_eq("reset_kills_read", {31'h0, flash_read}, 32'h0);
    step();
    reset_n = 1'b1;
    model_last = 1;
    clear_inputs();
    for (int i = 0; i < 3; i++) begin
      step();
      check_eq("no_pulse_after_reset", {30'h0, m1_ready, m0_ready}, 32'h0);
    end

    // Both ports hold reads: alternate under round-robin, port 0 under fixed priority.
    m0_sel = 1'b1; m0_read = 1'b1; m0_address = 32'h0000_1000;
    m1_sel = 1'b1; m1_read = 1'b1; m1_address = 32'h0000_2000;
    for (int i = 0; i < 4; i++) begin
      run_txn(3, 32'h5000_0000 + i, 1'b0, 1'b0, 1'b1, gg);
      check_eq("rr_order", gg, exp_order[i]);
    end
    clear_inputs();

    // Random traffic.
    for (int i = 0; i < 40; i++) begin
      m0_sel = ($urandom_range(0, 3) != 0);
      m0_read = 1'($urandom_range(0, 1));
      m0_mask = ($urandom_range(0, 1) != 0) ? 4'($urandom_range(0, 15)) : 4'h0;
      m0_address = $urandom;
      m1_sel = ($urandom_range(0, 3) != 0);
      m1_read = 1'($urandom_range(0, 1));
      m1_mask = ($urandom_range(0, 1) != 0) ? 4'($urandom_range(0, 15)) : 4'h0;
      m1_address = $urandom;
      run_txn($urandom_range(1, 8), $urandom, ($urandom_range(0, 5) == 0),
              1'($urandom_range(0, 1)), 1'b0, gg);
    end
    clear_inputs();
    step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
